// File: rtl/hex_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_scan
// Purpose  : Time-multiplexed driver for a common-anode N-digit 7-segment
//            display. One digit is lit per slot; anodes, segments and dp are
//            active-low and registered (1-clock latency from counters/inputs).
//            Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses
//            leading zero digits; digit 0 is never suppressed).
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_scan #(
    parameter int DIGITS      = 4,
    parameter int SLOT_CYCLES = 16384,
    parameter int GUARD       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     dash,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int                c_slot_w    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int                c_idx_w     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(SLOT_CYCLES - 1);
    localparam logic [c_slot_w-1:0] c_guard     = c_slot_w'(GUARD);
    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(DIGITS - 1);
    localparam logic [DIGITS-1:0]   c_an_one    = DIGITS'(1);
    localparam logic [6:0]          c_seg_off   = 7'h7F;
    localparam logic [6:0]          c_seg_dash  = 7'b0111111;

    logic [c_slot_w-1:0] r_slot_cnt;
    logic [c_idx_w-1:0]  r_idx;
    logic [DIGITS-1:0]   r_an;
    logic [6:0]          r_seg;
    logic                r_dp;

    logic [3:0]          w_nib;
    logic                w_in_guard;
    logic [DIGITS-1:0]   w_sup;
    logic [6:0]          w_seg;
    logic                w_dp;

    // Active-low glyph table, bit order gfedcba.
    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    assign w_nib      = value[{r_idx, 2'b00} +: 4];
    assign w_in_guard = (r_slot_cnt < c_guard);

`ifdef LEADING_ZERO_BLANK_EN
    logic w_run;

    // Walk from the most significant digit down; suppression stays armed while
    // every digit above is a hex zero or blanked.
    always_comb begin
        w_sup = '0;
        w_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_sup[i] = w_run && (i != 0) && !blank[i] && !dash[i] &&
                       (value[4*i +: 4] == 4'h0);
            w_run    = w_run && (blank[i] || (!dash[i] && (value[4*i +: 4] == 4'h0)));
        end
    end
`else
    assign w_sup = '0;
`endif

    // Decode the currently selected digit: blank beats dash beats hex.
    always_comb begin
        w_seg = f_glyph(w_nib);
        w_dp  = ~dp_in[r_idx];
        if (blank[r_idx]) begin
            w_seg = c_seg_off;
            w_dp  = 1'b1;
        end else if (dash[r_idx]) begin
            w_seg = c_seg_dash;
        end else if (w_sup[r_idx]) begin
            w_seg = c_seg_off;
        end
    end

    // Slot timer and digit index; the index advances when the slot wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_cnt <= '0;
            r_idx      <= '0;
        end else if (r_slot_cnt == c_slot_last) begin
            r_slot_cnt <= '0;
            r_idx      <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end
    end

    // Output registers; anodes stay dark during the guard window of each slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= '1;
            r_seg <= c_seg_off;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_in_guard ? '1 : ~(c_an_one << r_idx);
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_scan
// Purpose  : Self-checking bench for hex_display_scan (DIGITS=4,
//            SLOT_CYCLES=4, GUARD=1). A reference model predicts each edge's
//            outputs into a queue, which is popped and compared after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_scan;

    localparam int DIGITS = 4;
    localparam int SLOTS  = 4;
    localparam int GUARDN = 1;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [DIGITS-1:0] an;
        logic [6:0]        seg;
        logic              dp;
    } exp_t;

    logic                clk;
    logic                reset;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   dash;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                dp;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_slot = 0;
    int   m_idx  = 0;

    hex_display_scan #(
        .DIGITS      (DIGITS),
        .SLOT_CYCLES (SLOTS),
        .GUARD       (GUARDN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .blank (blank),
        .dash  (dash),
        .dp_in (dp_in),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    initial clk = 1'b0;
    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Expected outputs for the coming edge, from model state and current inputs.
    function automatic exp_t model_out();
        exp_t       e;
        logic [3:0] nib;
        logic       sup;
        e.an = (m_slot < GUARDN) ? 4'hF : ~(4'b0001 << m_idx);
        nib  = value[4*m_idx +: 4];
        sup  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (m_idx > 0 && !dash[m_idx] && nib == 4'h0) begin
            sup = 1'b1;
            for (int j = m_idx + 1; j < DIGITS; j++)
                if (!(blank[j] || (!dash[j] && value[4*j +: 4] == 4'h0)))
                    sup = 1'b0;
        end
`endif
        if (blank[m_idx]) begin
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end else if (dash[m_idx]) begin
            e.seg = 7'b0111111;
            e.dp  = ~dp_in[m_idx];
        end else begin
            e.seg = sup ? 7'h7F : GLYPH[nib];
            e.dp  = ~dp_in[m_idx];
        end
        return e;
    endfunction

    task automatic check7(input string tag, input logic [6:0] got, input logic [6:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    // One clock: predict, advance the model across the edge, then compare.
    task automatic step(input string tag);
        exp_t e;
        exp_t g;
        if (reset) begin
            e.an  = '1;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end else begin
            e = model_out();
        end
        q.push_back(e);
        @(posedge clk);
        if (reset) begin
            m_slot = 0;
            m_idx  = 0;
        end else if (m_slot == SLOTS - 1) begin
            m_slot = 0;
            m_idx  = (m_idx == DIGITS - 1) ? 0 : m_idx + 1;
        end else begin
            m_slot++;
        end
        #1;
        g = q.pop_front();
        checks++;
        assert (an === g.an) else begin
            errors++;
            $error("FAIL %s an: observed %b expected %b", tag, an, g.an);
        end
        check7({tag, " seg"}, seg, g.seg);
        checks++;
        assert (dp === g.dp) else begin
            errors++;
            $error("FAIL %s dp: observed %b expected %b", tag, dp, g.dp);
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) step(tag);
    endtask

    // Advance until the model reaches the requested digit/slot, bounded.
    task automatic seek(input string tag, input int idx, input int slot);
        int n;
        n = 0;
        while (!(m_idx == idx && m_slot == slot) && n < 64) begin
            step(tag);
            n++;
        end
        checks++;
        assert (m_idx == idx && m_slot == slot) else begin
            errors++;
            $error("FAIL %s seek: observed idx %0d slot %0d expected idx %0d slot %0d",
                   tag, m_idx, m_slot, idx, slot);
        end
    endtask

    initial begin
        reset = 1'b1;
        value = '0;
        blank = '0;
        dash  = '0;
        dp_in = '0;

        run("reset", 2);
        check7("reset_seg", seg, 7'h7F);

        reset = 1'b0;
        value = 16'h12AF;
        run("scan_12AF", 2 * DIGITS * SLOTS);

        blank = 4'b0010;
        dash  = 4'b0010;
        dp_in = 4'b1111;
        run("blank_dash", DIGITS * SLOTS);

        blank = 4'b0000;
        dash  = 4'b1000;
        run("dash3", DIGITS * SLOTS);

        dash  = 4'b0000;
        dp_in = 4'b0000;
        value = 16'h0040;
        run("lzb_0040", DIGITS * SLOTS);

        value = 16'hB5D7;
        dp_in = 4'b0101;
        seek("pre_rst", 2, 2);
        reset = 1'b1;
        step("mid_rst");
        check7("mid_rst_an", {3'b000, an}, 7'h0F);
        reset = 1'b0;
        run("post_rst", 2 * SLOTS);

        value = 16'hC9E3;
        seek("pre_chg", 0, 1);
        check7("chg_before", seg, 7'b0110000);
        value[3:0] = 4'h8;
        step("chg");
        check7("chg_after", seg, 7'b0000000);
        run("tail", SLOTS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
